lockin_cordic_polar: RTL and testbench

Converts the lock-in amplifier's filtered quadrature pair (x, y) into magnitude and phase with an iterative vectoring-mode CORDIC. Sits directly downstream of the lock-in stage: it consumes one (x, y) sample per `tick_i` pulse, the lock-in's done strobe. It produces `r_o`/`phi_o` with a one-cycle `done_o` strobe for the readout/register path.

---
 rtl/lockin_cordic_polar_pkg.sv | 78 +++++++
 rtl/lockin_cordic_polar_step.sv | 46 ++++
 rtl/lockin_cordic_polar.sv | 185 ++++++++++++++++++
 tb/tb_lockin_cordic_polar.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lockin_cordic_polar_pkg.sv
// ----------------------------------------------------------------------------
// lockin_cordic_pkg
// Shared definitions for the lock-in polar converter:
//   state_e     controller states (idle / iterating / scaling)
//   GUARD_BITS  headroom bits on the internal x/y datapath
//   IDX_BITS    width of the micro-rotation index
//   atan_ref()  arctangent table at 32-bit phase scale (2^31 <-> pi)
//   KINV_REF    reciprocal CORDIC gain at 32-bit scale (2^31 <-> 1.0)
//   scale_ref() rescales a 32-bit-scale constant to a narrower NUM_BITS
// ----------------------------------------------------------------------------
package lockin_cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_SCALE = 2'd2
  } state_e;

  localparam int unsigned GUARD_BITS = 2;
  localparam int unsigned IDX_BITS   = 5;
  localparam int unsigned REF_BITS   = 32;

  // round(0.607252935 * 2^31)
  localparam logic [31:0] KINV_REF = 32'd1304065748;

  // round(2^31/pi * atan(2^-i)), i = 0..30
  function automatic logic [31:0] atan_ref(input logic [IDX_BITS-1:0] idx);
    logic [31:0] v;
    case (idx)
      5'd0:    v = 32'd536870912;
      5'd1:    v = 32'd316933406;
      5'd2:    v = 32'd167458907;
      5'd3:    v = 32'd85004756;
      5'd4:    v = 32'd42667331;
      5'd5:    v = 32'd21354465;
      5'd6:    v = 32'd10679838;
      5'd7:    v = 32'd5340245;
      5'd8:    v = 32'd2670163;
      5'd9:    v = 32'd1335087;
      5'd10:   v = 32'd667544;
      5'd11:   v = 32'd333772;
      5'd12:   v = 32'd166886;
      5'd13:   v = 32'd83443;
      5'd14:   v = 32'd41722;
      5'd15:   v = 32'd20861;
      5'd16:   v = 32'd10430;
      5'd17:   v = 32'd5215;
      5'd18:   v = 32'd2608;
      5'd19:   v = 32'd1304;
      5'd20:   v = 32'd652;
      5'd21:   v = 32'd326;
      5'd22:   v = 32'd163;
      5'd23:   v = 32'd81;
      5'd24:   v = 32'd41;
      5'd25:   v = 32'd20;
      5'd26:   v = 32'd10;
      5'd27:   v = 32'd5;
      5'd28:   v = 32'd3;
      5'd29:   v = 32'd1;
      5'd30:   v = 32'd1;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // Rounded right shift from the 32-bit reference scale down to nb bits.
  // All table values are below 2^31, so the rounding add cannot overflow.
  function automatic logic [31:0] scale_ref(input logic [31:0] v, input int unsigned nb);
    logic [31:0] acc;
    acc = v;
    if (nb < REF_BITS) begin
      acc = acc + (32'd1 << (REF_BITS - nb - 1));
      acc = acc >> (REF_BITS - nb);
    end
    return acc;
  endfunction

endpackage

// File: rtl/lockin_cordic_polar_step.sv
// ----------------------------------------------------------------------------
// cordic_vector_step
// One combinational vectoring-mode micro-rotation. Drives y toward zero:
// the rotation direction follows the sign of the incoming y, and both
// updates use the pre-step x and y.
//   x_i, y_i   current vector (XY_BITS signed)
//   z_i        accumulated phase (NUM_BITS signed, wraps)
//   idx_i      micro-rotation index i (shift amount)
//   atan_i     ATAN[i] at NUM_BITS phase scale
//   x_o,y_o,z_o  rotated vector and updated phase
// ----------------------------------------------------------------------------
module cordic_vector_step
  import lockin_cordic_pkg::*;
#(
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned XY_BITS  = NUM_BITS + 2
) (
  input  logic signed [XY_BITS-1:0]  x_i,
  input  logic signed [XY_BITS-1:0]  y_i,
  input  logic signed [NUM_BITS-1:0] z_i,
  input  logic        [IDX_BITS-1:0] idx_i,
  input  logic        [NUM_BITS-1:0] atan_i,
  output logic signed [XY_BITS-1:0]  x_o,
  output logic signed [XY_BITS-1:0]  y_o,
  output logic signed [NUM_BITS-1:0] z_o
);

  logic signed [XY_BITS-1:0] x_sh_s;
  logic signed [XY_BITS-1:0] y_sh_s;

  // Micro-rotation: rotate clockwise when y >= 0, counter-clockwise otherwise.
  always_comb begin
    x_sh_s = x_i >>> idx_i;
    y_sh_s = y_i >>> idx_i;
    if (y_i[XY_BITS-1] == 1'b0) begin
      x_o = x_i + y_sh_s;
      y_o = y_i - x_sh_s;
      z_o = z_i + $signed(atan_i);
    end else begin
      x_o = x_i - y_sh_s;
      y_o = y_i + x_sh_s;
      z_o = z_i - $signed(atan_i);
    end
  end

endmodule

// File: rtl/lockin_cordic_polar.sv
// ----------------------------------------------------------------------------
// lockin_cordic_polar
// Iterative vectoring CORDIC turning the lock-in (x, y) pair into magnitude
// and phase. One sample per tick_i; result after NUM_ITER+2 cycles.
//   clk_i      clock
//   reset_ni   asynchronous active-low reset
//   tick_i     one-cycle sample strobe (lock-in done)
//   x_i, y_i   signed quadrature pair
//   r_o        unsigned magnitude, input LSB weight, saturating
//   phi_o      signed phase, +/-2^(NUM_BITS-1) <-> +/-pi
//   done_o     one-cycle result strobe
//   overrun_o  sticky: a tick arrived while a sample was in flight
// ----------------------------------------------------------------------------
module lockin_cordic_polar
  import lockin_cordic_pkg::*;
#(
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned NUM_ITER = 24
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       tick_i,
  input  logic signed [NUM_BITS-1:0] x_i,
  input  logic signed [NUM_BITS-1:0] y_i,
  output logic        [NUM_BITS-1:0] r_o,
  output logic signed [NUM_BITS-1:0] phi_o,
  output logic                       done_o,
  output logic                       overrun_o
);

  localparam int unsigned XY_BITS   = NUM_BITS + GUARD_BITS;
  localparam int unsigned PROD_BITS = XY_BITS + NUM_BITS + 1;
  localparam logic [NUM_BITS-1:0] KINV = NUM_BITS'(scale_ref(KINV_REF, NUM_BITS));
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_ITER - 1);
  // A quarter turn (pi/2) in phase units.
  localparam logic signed [NUM_BITS-1:0] Z_QUARTER = {2'b01, {(NUM_BITS-2){1'b0}}};

  state_e                     state_q, state_d;
  logic signed [XY_BITS-1:0]  x_q, x_d, y_q, y_d;
  logic signed [NUM_BITS-1:0] z_q, z_d;
  logic        [IDX_BITS-1:0] idx_q, idx_d;
  logic                       zero_q, zero_d;
  logic        [NUM_BITS-1:0] r_q, r_d;
  logic signed [NUM_BITS-1:0] phi_q, phi_d;
  logic                       done_q, done_d;
  logic                       overrun_q, overrun_d;

  logic signed [XY_BITS-1:0]   x_in_s, y_in_s;
  logic signed [XY_BITS-1:0]   step_x_s, step_y_s;
  logic signed [NUM_BITS-1:0]  step_z_s;
  logic        [NUM_BITS-1:0]  atan_s;
  logic signed [PROD_BITS-1:0] prod_s, scaled_s;
  logic        [NUM_BITS-1:0]  r_sat_s;

  assign x_in_s = {{GUARD_BITS{x_i[NUM_BITS-1]}}, x_i};
  assign y_in_s = {{GUARD_BITS{y_i[NUM_BITS-1]}}, y_i};
  assign atan_s = NUM_BITS'(scale_ref(atan_ref(idx_q), NUM_BITS));

  // Single shared micro-rotation, stepped once per ITER cycle.
  cordic_vector_step #(
    .NUM_BITS (NUM_BITS),
    .XY_BITS  (XY_BITS)
  ) u_step (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .idx_i  (idx_q),
    .atan_i (atan_s),
    .x_o    (step_x_s),
    .y_o    (step_y_s),
    .z_o    (step_z_s)
  );

  // Gain compensation: r = (x * KINV) >>> (NUM_BITS-1), clamped to [0, 2^NUM_BITS-1].
  always_comb begin
    prod_s   = PROD_BITS'(x_q) * PROD_BITS'($signed({1'b0, KINV}));
    scaled_s = prod_s >>> (NUM_BITS - 1);
    if (scaled_s[PROD_BITS-1] == 1'b1) begin
      r_sat_s = {NUM_BITS{1'b0}};
    end else if (scaled_s[PROD_BITS-2:NUM_BITS] != {(PROD_BITS-1-NUM_BITS){1'b0}}) begin
      r_sat_s = {NUM_BITS{1'b1}};
    end else begin
      r_sat_s = scaled_s[NUM_BITS-1:0];
    end
  end

  // Controller next state: load with half-plane pre-rotation, iterate, scale.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    idx_d     = idx_q;
    zero_d    = zero_q;
    r_d       = r_q;
    phi_d     = phi_q;
    done_d    = 1'b0;
    // Any tick outside IDLE (including the SCALE cycle) is dropped and remembered.
    overrun_d = overrun_q | (tick_i & (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (tick_i) begin
          // Rotate left-half-plane inputs by -/+ pi/2 so CORDIC stays in range.
          if (x_i[NUM_BITS-1] == 1'b0) begin
            x_d = x_in_s;
            y_d = y_in_s;
            z_d = {NUM_BITS{1'b0}};
          end else if (y_i[NUM_BITS-1] == 1'b0) begin
            x_d = y_in_s;
            y_d = -x_in_s;
            z_d = Z_QUARTER;
          end else begin
            x_d = -y_in_s;
            y_d = x_in_s;
            z_d = -Z_QUARTER;
          end
          idx_d   = {IDX_BITS{1'b0}};
          zero_d  = (x_i == {NUM_BITS{1'b0}}) && (y_i == {NUM_BITS{1'b0}});
          state_d = ST_ITER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        x_d   = step_x_s;
        y_d   = step_y_s;
        z_d   = step_z_s;
        idx_d = idx_q + IDX_BITS'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_SCALE;
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_SCALE: begin
        if (zero_q) begin
          r_d   = {NUM_BITS{1'b0}};
          phi_d = {NUM_BITS{1'b0}};
        end else begin
          r_d   = r_sat_s;
          phi_d = z_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      x_q       <= {XY_BITS{1'b0}};
      y_q       <= {XY_BITS{1'b0}};
      z_q       <= {NUM_BITS{1'b0}};
      idx_q     <= {IDX_BITS{1'b0}};
      zero_q    <= 1'b0;
      r_q       <= {NUM_BITS{1'b0}};
      phi_q     <= {NUM_BITS{1'b0}};
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      idx_q     <= idx_d;
      zero_q    <= zero_d;
      r_q       <= r_d;
      phi_q     <= phi_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign r_o       = r_q;
  assign phi_o     = phi_q;
  assign done_o    = done_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_lockin_cordic_polar.sv
// ----------------------------------------------------------------------------
// tb_lockin_cordic_polar
// Self-checking bench: ticks are scheduled on known clock edges, a reference
// model (real-valued sqrt/atan2 plus a busy-window acceptance rule) predicts
// which samples complete, when, and with what magnitude/phase; a monitor
// collects every done_o pulse for comparison.
// ----------------------------------------------------------------------------
module tb_lockin_cordic_polar;

  localparam int  NB  = 32;
  localparam int  NI  = 24;
  localparam int  LAT = NI + 1;   // edges from tick sample to the edge raising done_o
  localparam real PI  = 3.14159265358979323846;

  logic                 clk_i = 1'b0;
  logic                 reset_ni = 1'b0;
  logic                 tick_i = 1'b0;
  logic signed [NB-1:0] x_i = '0;
  logic signed [NB-1:0] y_i = '0;
  logic        [NB-1:0] r_o;
  logic signed [NB-1:0] phi_o;
  logic                 done_o;
  logic                 overrun_o;

  always #5 clk_i = ~clk_i;

  lockin_cordic_polar #(.NUM_BITS(NB), .NUM_ITER(NI)) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .tick_i    (tick_i),
    .x_i       (x_i),
    .y_i       (y_i),
    .r_o       (r_o),
    .phi_o     (phi_o),
    .done_o    (done_o),
    .overrun_o (overrun_o)
  );

  int     n_checks = 0;
  int     n_pass   = 0;
  longint cyc      = 0;

  // Expected completions (tick edge, inputs, phase tolerance) and observed ones.
  longint exp_k_q[$];
  longint exp_x_q[$];
  longint exp_y_q[$];
  longint exp_tp_q[$];
  longint done_cyc_q[$];
  longint done_r_q[$];
  longint done_phi_q[$];
  longint busy_until = -1;
  bit     ovr_exp    = 1'b0;
  logic   prev_done  = 1'b0;

  task automatic check_val(input string tag, input longint obs, input longint exp,
                           input longint tol, input bit wrap);
    longint diff;
    diff = obs - exp;
    if (wrap) begin
      diff = diff & 64'sh0000_0000_FFFF_FFFF;
      if (diff >= 64'sh0000_0000_8000_0000) diff = diff - 64'sh0000_0001_0000_0000;
    end
    if (diff < 0) diff = -diff;
    n_checks++;
    if (diff <= tol) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
  endtask

  function automatic longint model_r(input longint xv, input longint yv);
    real m;
    m = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
    if (m > 4294967295.0) m = 4294967295.0;
    return longint'(m);
  endfunction

  function automatic longint model_phi(input longint xv, input longint yv);
    longint p;
    if (xv == 0 && yv == 0) return 0;
    p = longint'($atan2(real'(yv), real'(xv)) / PI * 2147483648.0);
    if (p >= 64'sd2147483648) p = p - 64'sd4294967296;
    return p;
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Collect every done pulse; a pulse directly after another is an error.
  always @(negedge clk_i) begin
    if (done_o === 1'b1) begin
      check_val("done_single", longint'(prev_done), 0, 0, 1'b0);
      done_cyc_q.push_back(cyc);
      done_r_q.push_back(longint'(r_o));
      done_phi_q.push_back(longint'(phi_o));
    end
    prev_done <= done_o;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Present a one-cycle tick (called at a negedge); the next posedge samples it.
  task automatic send(input longint xv, input longint yv, input longint tp);
    longint k;
    x_i    = 32'(xv);
    y_i    = 32'(yv);
    tick_i = 1'b1;
    k      = cyc + 1;
    if (k > busy_until) begin
      exp_k_q.push_back(k);
      exp_x_q.push_back(xv);
      exp_y_q.push_back(yv);
      exp_tp_q.push_back(tp);
      busy_until = k + LAT;
    end else begin
      ovr_exp = 1'b1;
    end
    @(negedge clk_i);
    tick_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    longint dc, dr, dp, ek, ex, ey, et;
    bit     zero;
    repeat (LAT + 5) @(negedge clk_i);
    check_val({tag, "_ndone"}, longint'(done_cyc_q.size()), longint'(exp_k_q.size()), 0, 1'b0);
    while (done_cyc_q.size() > 0 && exp_k_q.size() > 0) begin
      dc = done_cyc_q.pop_front();
      dr = done_r_q.pop_front();
      dp = done_phi_q.pop_front();
      ek = exp_k_q.pop_front();
      ex = exp_x_q.pop_front();
      ey = exp_y_q.pop_front();
      et = exp_tp_q.pop_front();
      zero = (ex == 0) && (ey == 0);
      check_val({tag, "_lat"}, dc - ek, LAT, 0, 1'b0);
      check_val({tag, "_r"}, dr, model_r(ex, ey), zero ? 0 : 64, 1'b0);
      check_val({tag, "_phi"}, dp, model_phi(ex, ey), zero ? 0 : et, 1'b1);
    end
    done_cyc_q.delete(); done_r_q.delete(); done_phi_q.delete();
    exp_k_q.delete(); exp_x_q.delete(); exp_y_q.delete(); exp_tp_q.delete();
    check_val({tag, "_ovr"}, longint'(overrun_o), longint'(ovr_exp), 0, 1'b0);
  endtask

  // Reset at a negedge; outputs must clear at once, nothing in flight survives.
  task automatic apply_reset(input string tag);
    @(negedge clk_i);
    reset_ni = 1'b0;
    tick_i   = 1'b0;
    #1;
    check_val({tag, "_r0"},   longint'(r_o),       0, 0, 1'b0);
    check_val({tag, "_phi0"}, longint'(phi_o),     0, 0, 1'b0);
    check_val({tag, "_done0"}, longint'(done_o),   0, 0, 1'b0);
    check_val({tag, "_ovr0"}, longint'(overrun_o), 0, 0, 1'b0);
    wait_cyc(2);
    reset_ni = 1'b1;
    exp_k_q.delete(); exp_x_q.delete(); exp_y_q.delete(); exp_tp_q.delete();
    busy_until = cyc;
    ovr_exp    = 1'b0;
  endtask

  initial begin
    longint xv, yv, ax, ay;
    // Power-on reset held across clock edges.
    apply_reset("por");

    // Directed points.
    @(negedge clk_i);
    send(64'sd1073741824, 64'sd0, 128);           drain("pos_x");
    send(64'sd0, 64'sd1073741824, 128);           drain("pos_y");
    send(-64'sd1073741824, 64'sd0, 128);          drain("neg_x");
    send(-64'sd2147483648, -64'sd2147483648, 128); drain("corner");
    send(64'sd0, 64'sd0, 0);                      drain("zero");
    send(-64'sd700000000, 64'sd1500000000, 128);  drain("q2");

    // Back-to-back at full throughput: both accepted, no overrun.
    send(64'sd1200000000, -64'sd900000000, 128); wait_cyc(25);
    send(-64'sd500000000, -64'sd1900000000, 128); drain("b2b");

    // Tick coinciding with the SCALE cycle is dropped and flags overrun.
    send(64'sd1000000000, 64'sd1000000000, 128); wait_cyc(24);
    send(64'sd300000000, 64'sd900000000, 128);    drain("scale_tick");

    // Overrun is sticky; a tick 5 cycles in leaves the first result intact.
    send(64'sd1073741824, 64'sd0, 128); wait_cyc(4);
    send(-64'sd1800000000, 64'sd200000000, 128);  drain("tick5");

    // Reset clears overrun.
    apply_reset("clr");

    // Reset 10 cycles into a computation: no done, then a fresh sample works.
    @(negedge clk_i);
    send(64'sd1073741824, 64'sd1073741824, 128); wait_cyc(9);
    apply_reset("abort");
    drain("abort");
    send(64'sd1073741824, 64'sd0, 128);           drain("fresh");

    // Randomized full-scale samples at or near full throughput.
    for (int n = 0; n < 16; n++) begin
      do begin
        xv = longint'($signed($urandom()));
        yv = longint'($signed($urandom()));
        ax = (xv < 0) ? -xv : xv;
        ay = (yv < 0) ? -yv : yv;
      end while (ax < 64'sd536870912 && ay < 64'sd536870912);
      send(xv, yv, 256);
      wait_cyc(int'($urandom_range(27, 25)));
    end
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
